// File: rtl/pipe_chain_if.sv
// pipe_chain_if: upstream/downstream handshake bundle for pipe_chain.
// The master side drives the entry (in_valid/in_data) and observes the chain
// tail; the slave side is the chain itself.
interface pipe_chain_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage payload register chain with per-stage valid,
// stall at a selectable stage (bubble inserted just below it), per-stage
// flush and a registered occupancy count.
// Optional feature macro: PIPE_CHAIN_PERF_EN builds the retired/bubble
// performance counters; without it both perf ports are tied to 0.
module pipe_chain #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  pipe_chain_if.slave            bus,
  input  logic                   stall_req_i,
  input  logic [SW-1:0]          stall_stage_i,
  input  logic [DEPTH-1:0]       flush_mask_i,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [DEPTH*WIDTH-1:0] stage_data_o,
  output logic [SW:0]            occupancy_o,
  output logic [31:0]            perf_retired_o,
  output logic [31:0]            perf_bubbles_o
);

  // Stall stage widened so the compares below never wrap; values beyond
  // DEPTH-1 simply hold every stage and leave no stage to bubble.
  logic [31:0] stall_stage_w;
  assign stall_stage_w = 32'(stall_stage_i);

  logic [DEPTH-1:0] valid_q, valid_d, src_valid;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_d   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [SW:0]      occ_q, occ_d;

  assign src_valid = {valid_q[DEPTH-2:0], bus.in_valid};

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    src_data[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_data[i] = data_q[i-1];
    end
  end

  // Next state per stage: flush > hold > bubble > load; invalid stages carry zero data.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = 1'b0;
      data_d[i]  = '0;
      if (!flush_mask_i[i]) begin
        if (stall_req_i && (32'(i) <= stall_stage_w)) begin
          valid_d[i] = valid_q[i];
          data_d[i]  = data_q[i];
        end else if (!(stall_req_i && (32'(i) == stall_stage_w + 32'd1)) && src_valid[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = src_data[i];
        end
      end
      occ_d = occ_d + (SW+1)'(valid_d[i]);
    end
  end

  // Stage registers and occupancy, cleared by synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage_out
    assign stage_data_o[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign stage_valid_o = valid_q;
  assign occupancy_o   = occ_q;
  assign bus.in_ready  = !stall_req_i;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];

`ifdef PIPE_CHAIN_PERF_EN
  logic        bubble_fire;
  logic [31:0] retired_q, retired_d;
  logic [31:0] bubbles_q, bubbles_d;

  // A bubble counts only when the stage below the stall is not being flushed.
  always_comb begin
    bubble_fire = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (stall_req_i && !flush_mask_i[i] && (32'(i) == stall_stage_w + 32'd1)) begin
        bubble_fire = 1'b1;
      end
    end
    retired_d = retired_q + 32'(valid_q[DEPTH-1]);
    bubbles_d = bubbles_q + 32'(bubble_fire);
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      retired_q <= '0;
      bubbles_q <= '0;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_retired_o = retired_q;
  assign perf_bubbles_o = bubbles_q;
`else
  assign perf_retired_o = 32'd0;
  assign perf_bubbles_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed scenarios for pipe_chain (WIDTH=32, DEPTH=4).
// Entries expected to retire are queued at issue; a negedge monitor pops and
// compares each new entry presented at the chain tail.
module tb_pipe_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 2;
`ifdef PIPE_CHAIN_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall_req;
  logic [SW-1:0]          stall_stage;
  logic [DEPTH-1:0]       flush_mask;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [SW:0]            occupancy;
  logic [31:0]            perf_retired;
  logic [31:0]            perf_bubbles;

  always #5 clk = ~clk;

  pipe_chain_if #(.WIDTH(WIDTH)) bus ();

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .bus            (bus),
    .stall_req_i    (stall_req),
    .stall_stage_i  (stall_stage),
    .flush_mask_i   (flush_mask),
    .stage_valid_o  (stage_valid),
    .stage_data_o   (stage_data),
    .occupancy_o    (occupancy),
    .perf_retired_o (perf_retired),
    .perf_bubbles_o (perf_bubbles)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  logic        prev_hold = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
    return PERF_EN ? v : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic st,
                       input logic [1:0] ss, input logic [3:0] fm);
    bus.in_valid = v;
    bus.in_data  = d;
    stall_req    = st;
    stall_stage  = ss;
    flush_mask   = fm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stages(input string name, input logic [3:0] v,
                            input logic [31:0] s3, input logic [31:0] s2,
                            input logic [31:0] s1, input logic [31:0] s0);
    chk({name, "_valid"}, 128'(stage_valid), 128'(v));
    chk({name, "_data"},  128'(stage_data),  {s3, s2, s1, s0});
    chk({name, "_occ"},   128'(occupancy),   128'($countones(v)));
    chk({name, "_ovld"},  128'(bus.out_valid), 128'(v[3]));
    chk({name, "_odata"}, 128'(bus.out_data),  128'(s3));
  endtask

  task automatic chk_perf(input string name, input logic [31:0] ret, input logic [31:0] bub);
    chk({name, "_retired"}, 128'(perf_retired), 128'(perf_exp(ret)));
    chk({name, "_bubbles"}, 128'(perf_bubbles), 128'(perf_exp(bub)));
  endtask

  // Scoreboard monitor: a tail entry is compared once, skipping cycles where it was frozen.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && !prev_hold) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no entry", bus.out_data);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_out", 128'(bus.out_data), 128'(sb_e));
      end
    end
    prev_hold = !rst && stall_req && (stall_stage == 2'd3) && !flush_mask[3];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sdat [5];
    logic [2:0]  socc [5];
    logic [31:0] afill [4];
    sdat  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    socc  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    afill = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

    // reset, with in_ready following stall_req throughout
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 2'd0, 4'b0000);
    tick();
    chk("rst_in_ready_stall", 128'(bus.in_ready), 128'(1'b0));
    drive(1'b0, 32'h0, 1'b0, 2'd0, 4'b0000);
    #1;
    chk("rst_in_ready_free", 128'(bus.in_ready), 128'(1'b1));
    tick();
    rst = 1'b0;
    chk_stages("reset", 4'b0000, 0, 0, 0, 0);
    chk_perf("reset", 0, 0);

    // streaming
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sdat[i], 1'b0, 2'd0, 4'b0000);
      exp_q.push_back(sdat[i]);
      tick();
      chk("stream_occ", 128'(occupancy), 128'(socc[i]));
      if (i == 3) chk("stream_first_out", 128'(bus.out_data), 128'(32'h11));
    end
    chk_stages("stream", 4'b1111, 32'h22, 32'h33, 32'h44, 32'h55);

    // stall at stage 1 for two cycles, upstream holds 0x66
    drive(1'b1, 32'h66, 1'b1, 2'd1, 4'b0000);
    #1;
    chk("stall_in_ready0", 128'(bus.in_ready), 128'(1'b0));
    tick();
    chk("stall_in_ready1", 128'(bus.in_ready), 128'(1'b0));
    chk_stages("stall1", 4'b1011, 32'h33, 0, 32'h44, 32'h55);
    tick();
    chk_stages("stall2", 4'b0011, 0, 0, 32'h44, 32'h55);
    chk_perf("stall", 3, 2);

    // release and refill; 0x77 and 0x88 are flushed below and never retire
    drive(1'b1, 32'h66, 1'b0, 2'd0, 4'b0000);
    exp_q.push_back(32'h66);
    #1;
    chk("release_in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    chk_stages("release", 4'b0111, 0, 32'h44, 32'h55, 32'h66);
    drive(1'b1, 32'h77, 1'b0, 2'd0, 4'b0000);
    tick();
    drive(1'b1, 32'h88, 1'b0, 2'd0, 4'b0000);
    tick();
    chk_stages("refill", 4'b1111, 32'h55, 32'h66, 32'h77, 32'h88);

    // flush stages 0..2
    drive(1'b0, 32'h0, 1'b0, 2'd0, 4'b0111);
    tick();
    chk_stages("flush", 4'b1000, 32'h66, 0, 0, 0);

    // fill A1..A4; A3 is flushed below and never retires
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, afill[i], 1'b0, 2'd0, 4'b0000);
      if (i != 2) exp_q.push_back(afill[i]);
      tick();
    end
    chk_stages("fill2", 4'b1111, 32'hA1, 32'hA2, 32'hA3, 32'hA4);

    // flush during stall at stage 2
    drive(1'b1, 32'hA5, 1'b1, 2'd2, 4'b0010);
    tick();
    chk_stages("flush_stall", 4'b0101, 0, 32'hA2, 0, 32'hA4);
    chk_perf("flush_stall", 7, 3);

    drive(1'b1, 32'hA5, 1'b0, 2'd0, 4'b0000);
    tick();
    chk_stages("release2", 4'b1011, 32'hA2, 0, 32'hA4, 32'hA5);

    // freeze whole chain for two cycles with a live tail entry
    drive(1'b1, 32'hA6, 1'b1, 2'd3, 4'b0000);
    tick();
    tick();
    chk_stages("freeze", 4'b1011, 32'hA2, 0, 32'hA4, 32'hA5);
    chk_perf("freeze", 9, 3);

    // refill; A5..A7 are discarded by the reset below
    drive(1'b1, 32'hA6, 1'b0, 2'd0, 4'b0000);
    tick();
    drive(1'b1, 32'hA7, 1'b0, 2'd0, 4'b0000);
    tick();
    chk_stages("full3", 4'b1111, 32'hA4, 32'hA5, 32'hA6, 32'hA7);

    // reset mid-stream; the entry presented at the reset edge is dropped
    rst = 1'b1;
    drive(1'b1, 32'hEE, 1'b0, 2'd0, 4'b0000);
    tick();
    rst = 1'b0;
    chk_stages("rst_mid", 4'b0000, 0, 0, 0, 0);
    chk_perf("rst_mid", 0, 0);

    // resume streaming and drain
    drive(1'b1, 32'hB1, 1'b0, 2'd0, 4'b0000);
    exp_q.push_back(32'hB1);
    tick();
    drive(1'b1, 32'hB2, 1'b0, 2'd0, 4'b0000);
    exp_q.push_back(32'hB2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 2'd0, 4'b0000);
    tick();
    tick();
    chk_stages("drain1", 4'b1100, 32'hB1, 32'hB2, 0, 0);
    tick();
    chk_stages("drain2", 4'b1000, 32'hB2, 0, 0, 0);
    chk_perf("drain2", 1, 0);
    tick();
    chk_stages("drain3", 4'b0000, 0, 0, 0, 0);
    chk_perf("drain3", 2, 0);
    tick();
    chk("sb_leftover", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised pipeline register chain carrying one WIDTH-bit payload through DEPTH stages, each with a valid bit. It replaces hand-written per-signal daisy chains between the fetch, decode, execute, memory and write-back stages of the core. Beyond plain delay it provides:
- a valid bit per stage
- stall at a selectable stage, with automatic bubble insertion below the stall
- per-stage flush
- an occupancy count

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 4, number of stages (≥2); SW = $clog2(DEPTH)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  payload at in_data is a live entry
- in_data  in  WIDTH  payload entering stage 0
- in_ready  out  1  stage 0 accepts this cycle; equals !stall_req
- stall_req  in  1  hold request
- stall_stage  in  SW  oldest stage held while stall_req=1
- flush_mask  in  DEPTH  bit i forces stage i to a bubble at the next edge
- stage_valid  out  DEPTH  valid bit of each stage register
- stage_data  out  DEPTH*WIDTH  stage i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  1  equals stage_valid[DEPTH-1]
- out_data  out  WIDTH  equals stage i = DEPTH-1 data
- occupancy  out  SW+1  number of set stage_valid bits (registered)
- perf_retired  out  32  count of cycles with out_valid=1 (see Configuration)
- perf_bubbles  out  32  count of bubbles inserted by stalls (see Configuration)

## Operation
- Stage i register is {valid_i, data_i}. Stage 0 is sourced from {in_valid, in_data}; stage i>0 is sourced from stage i-1.
- Define held(i) = stall_req && (i ≤ stall_stage).
- Next-state priority per stage i, at every rising edge, highest first:
  1. reset → valid=0, data=0.
  2. flush_mask[i] → valid=0, data=0.
  3. held(i) → keep current contents.
  4. stall_req && i == stall_stage+1 → bubble: valid=0, data=0.
  5. otherwise → load from source.
- A bubble always carries data=0. The data of an invalid stage is always 0.
- Input handshake:
  - An entry is accepted when in_valid && in_ready.
  - While in_ready=0, upstream must hold in_valid and in_data stable.
  - in_valid=0 with in_ready=1 loads a bubble into stage 0.
- Flush usage: a branch resolved in stage K kills younger entries by asserting flush_mask bits 0..K. Those are the stages whose next contents are the younger entries.
- Stall with stall_stage ≥ DEPTH-1: the whole chain freezes and no bubble is inserted. Values above DEPTH-1 are treated as DEPTH-1.
- Flush overrides stall: a held stage with its flush bit set becomes a bubble. Unflushed held stages keep their contents.
- occupancy is updated at the same edge as the stage registers and equals the popcount of the new stage_valid. Reset value is 0.
- Combinational paths: in_ready depends only on stall_req. All other outputs are registered.

## Timing
- Latency: an entry accepted at edge n appears at stage i after edge n+i, when no stalls occur. out_valid is then asserted after edge n+DEPTH-1.
- Each stall cycle adds one cycle of latency to every entry at or above stall_stage.
- The bubble appears in stage stall_stage+1 on the edge following any cycle in which stall_req=1.
- Reset values:
  - stage_valid=0, stage_data=0, out_valid=0, out_data=0
  - occupancy=0, perf counters=0
  - in_ready follows stall_req during reset.
- Reset mid-operation discards all entries on the reset edge. Entries presented at the same edge as reset are not captured.

## Configuration
- PIPE_CHAIN_PERF_EN defined:
  - perf_retired increments on each edge where out_valid=1 before the edge.
  - perf_bubbles increments on each edge where rule 4 fires.
  - Both counters wrap modulo 2^32 and clear on reset.
- PIPE_CHAIN_PERF_EN undefined: both ports are present and tied to 0, and no counter flops are built.

## Test plan
All scenarios use WIDTH=32, DEPTH=4.
- Streaming: feed 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → out_data shows 0x11 three edges after its acceptance, then one value per cycle; occupancy climbs 1, 2, 3, 4 and stays at 4.
- Stall at stage 1 for 2 cycles with the chain full of A(s3) B(s2) C(s1) D(s0):
  - in_ready=0 for 2 cycles.
  - Stages 0 and 1 hold D and C.
  - Stage 2 receives bubbles with data=0.
  - A and B drain.
  - perf_bubbles=2 with the macro defined.
- Flush: chain full, assert flush_mask=4'b0111 for one cycle → only the old stage-2 entry advances to stage 3; stages 0-2 are invalid with data 0; occupancy=1.
- Flush during stall: stall_req=1, stall_stage=2, flush_mask=4'b0010 → stage 1 becomes a bubble; stages 0 and 2 are held; stage 3 becomes a bubble.
- Freeze: stall_stage=3 → all four stages unchanged and no bubble; perf_bubbles unchanged.
- Reset mid-stream: assert reset with the chain full → next edge shows stage_valid=0, occupancy=0, perf counters 0; streaming resumes after reset deasserts.
